// File: rtl/vector_checker_pkg.sv
// Shared types, sizes and the truth-table lookup for the vector checker.
package vector_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned LOG_DEPTH = 4;
  localparam int unsigned MAX_N_IN  = 8;
  localparam int unsigned MAX_VEC   = 2 ** MAX_N_IN;

  // Expected DUT output for one input vector; truth is zero-extended by the caller.
  function automatic logic expected_y(input logic [MAX_VEC-1:0] truth,
                                      input logic [MAX_N_IN-1:0] vec);
    return truth[vec];
  endfunction

endpackage

// File: rtl/fail_log_fifo.sv
// Small synchronous FIFO holding mismatching samples; pushes when full are dropped.
module fail_log_fifo
  import vector_checker_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(LOG_DEPTH);

  logic [W-1:0]  mem [LOG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(LOG_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && reset_n && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vector_checker.sv
// Checks (vector, observed y) samples against a truth table and reports pass/fail.
// Optional failure log enabled by defining VECTOR_CHECKER_LOG_EN.
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int unsigned            N_IN  = 3,
  parameter logic [(2**N_IN)-1:0]   TRUTH = 8'h31,
  parameter int unsigned            ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_y,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
`ifdef VECTOR_CHECKER_LOG_EN
  ,
  input  logic             log_pop,
  output logic             log_empty,
  output logic [N_IN-1:0]  log_vec,
  output logic             log_y
`endif
);

  localparam int unsigned NUM_VEC = 2 ** N_IN;
  localparam int unsigned CNT_W   = N_IN + 1;

  state_t             state;
  state_t             state_next;
  logic               xfer;
  logic               mismatch;
  logic               last;
  logic [CNT_W-1:0]   sample_cnt;
  logic [NUM_VEC-1:0] coverage;
  logic [NUM_VEC-1:0] cov_next;
  logic [ERR_W-1:0]   err_next;

  // A start cycle drops any offered sample.
  assign xfer     = in_valid & in_ready & ~start;
  assign mismatch = (in_y != expected_y(MAX_VEC'(TRUTH), MAX_N_IN'(in_vec)));
  assign last     = (sample_cnt == CNT_W'(NUM_VEC - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (start) state_next = RUN;
               else if (xfer && last) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if (state == RUN) in_ready = 1'b1;
  end

  // Saturating error count and coverage as they will be after this transfer.
  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != '1)) err_next = err_count + 1'b1;
    cov_next         = coverage;
    cov_next[in_vec] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      err_count      <= '0;
      coverage       <= '0;
      sample_cnt     <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (xfer) begin
      err_count  <= err_next;
      coverage   <= cov_next;
      sample_cnt <= sample_cnt + 1'b1;
      if (mismatch && !fail_valid) begin
        fail_valid     <= 1'b1;
        first_fail_vec <= in_vec;
      end
      if (last) begin
        done <= 1'b1;
        pass <= (err_next == '0) & (&cov_next);
      end
    end
  end

`ifdef VECTOR_CHECKER_LOG_EN
  logic log_full;

  fail_log_fifo #(.W(N_IN + 1)) u_fail_log (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .push    (xfer & mismatch & ~log_full),
    .pop     (log_pop),
    .din     ({in_vec, in_y}),
    .dout    ({log_vec, log_y}),
    .full    (log_full),
    .empty   (log_empty)
  );
`endif

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench for vector_checker: default instance plus an ERR_W=2 instance on shared stimulus.
module tb_vector_checker;

  localparam logic [7:0] TRUTH = 8'h31;

  typedef struct {
    logic [7:0] err;
    logic [1:0] err_sat;
    logic       fv;
    logic [2:0] ffv;
    logic       done;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_vec;
  logic       in_y;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       fail_valid;
  logic [2:0] first_fail_vec;

  logic       sat_in_ready;
  logic       sat_done;
  logic       sat_pass;
  logic [1:0] sat_err_count;
  logic       sat_fail_valid;
  logic [2:0] sat_first_fail_vec;

`ifdef VECTOR_CHECKER_LOG_EN
  logic       log_pop;
  logic       log_empty;
  logic [2:0] log_vec;
  logic       log_y;
  logic       sat_log_empty;
  logic [2:0] sat_log_vec;
  logic       sat_log_y;
  logic [3:0] log_q[$];
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  int       m_err;
  int       m_sat;
  logic     m_fv;
  logic [2:0] m_ffv;
  logic [7:0] m_cov;
  int       m_cnt;

  always #5 clk = ~clk;

  vector_checker #(.N_IN(3), .TRUTH(TRUTH), .ERR_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_vec         (in_vec),
    .in_y           (in_y),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .fail_valid     (fail_valid),
    .first_fail_vec (first_fail_vec)
`ifdef VECTOR_CHECKER_LOG_EN
    ,
    .log_pop        (log_pop),
    .log_empty      (log_empty),
    .log_vec        (log_vec),
    .log_y          (log_y)
`endif
  );

  vector_checker #(.N_IN(3), .TRUTH(TRUTH), .ERR_W(2)) dut_sat (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (sat_in_ready),
    .in_vec         (in_vec),
    .in_y           (in_y),
    .done           (sat_done),
    .pass           (sat_pass),
    .err_count      (sat_err_count),
    .fail_valid     (sat_fail_valid),
    .first_fail_vec (sat_first_fail_vec)
`ifdef VECTOR_CHECKER_LOG_EN
    ,
    .log_pop        (log_pop),
    .log_empty      (sat_log_empty),
    .log_vec        (sat_log_vec),
    .log_y          (sat_log_y)
`endif
  );

  task automatic model_clear();
    m_err = 0; m_sat = 0; m_fv = 1'b0; m_ffv = 3'd0; m_cov = 8'd0; m_cnt = 0;
    sb.delete();
`ifdef VECTOR_CHECKER_LOG_EN
    log_q.delete();
`endif
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
  endtask

  // Offer one sample, wait (bounded) for acceptance, push the expected post-transfer state.
  task automatic send_sample(input logic [2:0] v, input logic y);
    int   budget;
    logic mis;
    exp_t e;
    budget   = 20;
    in_vec   = v;
    in_y     = y;
    in_valid = 1'b1;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1 (vec %0d)", in_ready, v);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    mis = (y !== TRUTH[v]);
    if (mis && m_err < 255) m_err++;
    if (mis && m_sat < 3) m_sat++;
    if (mis && !m_fv) begin m_fv = 1'b1; m_ffv = v; end
    m_cov[v] = 1'b1;
    m_cnt++;
`ifdef VECTOR_CHECKER_LOG_EN
    if (mis && log_q.size() < 4) log_q.push_back({v, y});
`endif
    e.err = 8'(m_err); e.err_sat = 2'(m_sat); e.fv = m_fv; e.ffv = m_ffv;
    e.done = (m_cnt == 8);
    e.pass = e.done && (m_err == 0) && (&m_cov);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = 3'd0; in_y = 1'b0;
`ifdef VECTOR_CHECKER_LOG_EN
    log_pop = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    n_checks++;
    if ({in_ready, done, pass, err_count, fail_valid, first_fail_vec} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%0b done=%0b pass=%0b err=%0d fv=%0b ffv=%0d, required all 0",
               in_ready, done, pass, err_count, fail_valid, first_fail_vec);
    end
    // Samples offered in IDLE are ignored.
    in_vec = 3'd3; in_y = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (err_count !== 8'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: got err=%0d rdy=%0b, required err=0 rdy=0", err_count, in_ready);
    end
  endtask

  task automatic test_clean_run();
    exp_t e;
    start_run();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL clean_ready: got %0b required 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      send_sample(3'(i), TRUTH[i]);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (err_count !== e.err || done !== e.done || pass !== e.pass) begin
          n_fail++;
          $display("FAIL clean_sample[%0d]: got err=%0d done=%0b pass=%0b, required err=%0d done=%0b pass=%0b",
                   i, err_count, done, pass, e.err, e.done, e.pass);
        end
      end
    end
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1 || fail_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_final: got done=%0b pass=%0b fv=%0b rdy=%0b, required 1 1 0 0",
               done, pass, fail_valid, in_ready);
    end
    // Offers in DONE are ignored and the result holds.
    in_vec = 3'd6; in_y = 1'b1; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (err_count !== 8'd0 || done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold: got err=%0d done=%0b pass=%0b, required 0 1 1", err_count, done, pass);
    end
  endtask

  task automatic test_two_errors();
    exp_t e;
    logic y;
    start_run();
    for (int i = 0; i < 8; i++) begin
      y = TRUTH[i];
      if (i == 3 || i == 6) y = 1'b1;
      send_sample(3'(i), y);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (err_count !== e.err || fail_valid !== e.fv || first_fail_vec !== e.ffv) begin
          n_fail++;
          $display("FAIL err_sample[%0d]: got err=%0d fv=%0b ffv=%0d, required err=%0d fv=%0b ffv=%0d",
                   i, err_count, fail_valid, first_fail_vec, e.err, e.fv, e.ffv);
        end
      end
    end
    n_checks++;
    if (err_count !== 8'd2 || first_fail_vec !== 3'b011 || fail_valid !== 1'b1 ||
        done !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL two_err_final: got err=%0d ffv=%0d fv=%0b done=%0b pass=%0b, required 2 3 1 1 0",
               err_count, first_fail_vec, fail_valid, done, pass);
    end
  endtask

  task automatic test_coverage_hole();
    exp_t e;
    logic [2:0] seq [8];
    seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    start_run();
    for (int i = 0; i < 8; i++) begin
      send_sample(seq[i], TRUTH[seq[i]]);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (done !== e.done || pass !== e.pass || err_count !== e.err) begin
          n_fail++;
          $display("FAIL cov_sample[%0d]: got done=%0b pass=%0b err=%0d, required %0b %0b %0d",
                   i, done, pass, err_count, e.done, e.pass, e.err);
        end
      end
    end
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL cov_final: got done=%0b pass=%0b err=%0d, required 1 0 0", done, pass, err_count);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    start_run();
    for (int i = 0; i < 8; i++) begin
      send_sample(3'(i), ~TRUTH[i]);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (sat_err_count !== e.err_sat || err_count !== e.err) begin
          n_fail++;
          $display("FAIL sat_sample[%0d]: got sat_err=%0d err=%0d, required sat_err=%0d err=%0d",
                   i, sat_err_count, err_count, e.err_sat, e.err);
        end
      end
    end
    n_checks++;
    if (sat_err_count !== 2'd3 || sat_done !== 1'b1 || sat_pass !== 1'b0 || err_count !== 8'd8) begin
      n_fail++;
      $display("FAIL sat_final: got sat_err=%0d sat_done=%0b sat_pass=%0b err=%0d, required 3 1 0 8",
               sat_err_count, sat_done, sat_pass, err_count);
    end
  endtask

  task automatic test_reset_restart();
    exp_t e;
    start_run();
    for (int i = 0; i < 4; i++) begin
      send_sample(3'(i), (i == 1) ? ~TRUTH[i] : TRUTH[i]);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_clear();
    n_checks++;
    if ({in_ready, done, pass, err_count, fail_valid, first_fail_vec} !== 15'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got rdy=%0b done=%0b pass=%0b err=%0d fv=%0b ffv=%0d, required all 0",
               in_ready, done, pass, err_count, fail_valid, first_fail_vec);
    end
    start_run();
    for (int i = 0; i < 3; i++) begin
      send_sample(3'(i), (i == 2) ? ~TRUTH[i] : TRUTH[i]);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    n_checks++;
    if (err_count !== 8'd1 || fail_valid !== 1'b1 || first_fail_vec !== 3'd2) begin
      n_fail++;
      $display("FAIL pre_restart: got err=%0d fv=%0b ffv=%0d, required 1 1 2", err_count, fail_valid, first_fail_vec);
    end
    // Restart with a mismatching sample offered in the same cycle; it must be dropped.
    in_vec = 3'd7; in_y = ~TRUTH[7]; in_valid = 1'b1;
    start_run();
    in_valid = 1'b0;
    n_checks++;
    if (err_count !== 8'd0 || fail_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got err=%0d fv=%0b rdy=%0b done=%0b, required 0 0 1 0",
               err_count, fail_valid, in_ready, done);
    end
    for (int i = 7; i >= 0; i--) begin
      send_sample(3'(i), TRUTH[i]);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (done !== e.done || pass !== e.pass || err_count !== e.err) begin
          n_fail++;
          $display("FAIL restart_sample[%0d]: got done=%0b pass=%0b err=%0d, required %0b %0b %0d",
                   i, done, pass, err_count, e.done, e.pass, e.err);
        end
      end
    end
  endtask

`ifdef VECTOR_CHECKER_LOG_EN
  task automatic test_fail_log();
    logic [3:0] h;
    start_run();
    for (int i = 0; i < 6; i++) begin
      send_sample(3'(i), ~TRUTH[i]);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (log_q.size() != 0) begin
        h = log_q.pop_front();
        n_checks++;
        if (log_empty !== 1'b0 || {log_vec, log_y} !== h) begin
          n_fail++;
          $display("FAIL log_head[%0d]: got empty=%0b vec=%0d y=%0b, required empty=0 vec=%0d y=%0b",
                   i, log_empty, log_vec, log_y, h[3:1], h[0]);
        end
      end
      log_pop = 1'b1;
      @(posedge clk); #1;
      log_pop = 1'b0;
    end
    n_checks++;
    if (log_empty !== 1'b1) begin
      n_fail++; $display("FAIL log_drained: got empty=%0b required 1", log_empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_run();
    test_two_errors();
    test_coverage_hole();
    test_saturation();
    test_reset_restart();
`ifdef VECTOR_CHECKER_LOG_EN
    test_fail_log();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
